// File: rtl/dm_store_buffer_if.sv
// Store-path, load-lookup and data-memory signals of the posted-write store buffer.
// slave is the buffer side; master is the pipeline/DM side.
interface dm_store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_be, st_pc, ld_valid, ld_addr, dm_ready,
    output st_ready, ld_conflict, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_be, st_pc, ld_valid, ld_addr, dm_ready,
    input  st_ready, ld_conflict, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: queues byte/half/word stores, merges same-word stores
// into the youngest entry, drains FIFO into data memory and flags load hits.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic               clk,
  input logic               reset,
  dm_store_buffer_if.slave  sb
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [29:0]      waddr_q [DEPTH];
  logic [29:0]      waddr_d [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [3:0]       be_d    [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop_c;
  logic             push_c;
  logic             coalesce_c;
  logic             alloc_c;
  logic [PTR_W-1:0] tail_m1_c;
  logic             hit_c;
  logic             unused_c;

  // Word-address bits [1:0] carry no information; lane position lives in the byte enables.
  assign unused_c = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign sb.empty    = (count_q == '0);
  assign sb.st_ready = (count_q != CNT_W'(DEPTH));
  assign sb.dm_we    = (count_q != '0);
  assign sb.dm_addr  = {waddr_q[head_q], 2'b00};
  assign sb.dm_wd    = data_q[head_q];
  assign sb.dm_be    = be_q[head_q];
  assign sb.dm_pc    = pc_q[head_q];

  assign tail_m1_c = tail_q - PTR_W'(1);
  assign pop_c     = sb.dm_we && sb.dm_ready;
  assign push_c    = sb.st_valid && sb.st_ready && (sb.st_be != 4'b0000);
  // Never merge into the entry that is leaving this cycle.
  assign coalesce_c = push_c && (count_q != '0)
                      && (sb.st_addr[31:2] == waddr_q[tail_m1_c])
                      && !((count_q == CNT_W'(1)) && pop_c);
  assign alloc_c    = push_c && !coalesce_c;

  // Load lookup over the occupied window [head, head+count).
  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q)
          && (waddr_q[i] == sb.ld_addr[31:2])) begin
        hit_c = 1'b1;
      end
    end
  end

  assign sb.ld_conflict = sb.ld_valid && hit_c;

  // Next-state: pop, merge or allocate.
  always_comb begin
    waddr_d = waddr_q;
    data_d  = data_q;
    be_d    = be_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(alloc_c) - CNT_W'(pop_c);

    if (pop_c) begin
      be_d[head_q] = 4'b0000;
      head_d       = head_q + PTR_W'(1);
    end

    if (coalesce_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sb.st_be[b]) begin
          data_d[tail_m1_c][8*b +: 8] = sb.st_data[8*b +: 8];
        end
      end
      be_d[tail_m1_c] = be_q[tail_m1_c] | sb.st_be;
      pc_d[tail_m1_c] = sb.st_pc;
    end

    if (alloc_c) begin
      waddr_d[tail_q] = sb.st_addr[31:2];
      data_d[tail_q]  = sb.st_data;
      be_d[tail_q]    = sb.st_be;
      pc_d[tail_q]    = sb.st_pc;
      tail_d          = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the buffer.
module tb_dm_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dm_store_buffer_if sb ();

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];

  // Model of one clock edge, taken from the current inputs and queue contents.
  function automatic void model_edge();
    bit   pop;
    bit   push;
    ent_t e;
    pop  = (q.size() > 0) && sb.dm_ready;
    push = sb.st_valid && (q.size() < DEPTH) && (sb.st_be != 4'b0000);
    if (push && q.size() > 0 && q[q.size()-1].w == sb.st_addr[31:2] && !(q.size() == 1 && pop)) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++)
        if (sb.st_be[b]) e.d[8*b +: 8] = sb.st_data[8*b +: 8];
      e.be = e.be | sb.st_be;
      e.pc = sb.st_pc;
      q[q.size()-1] = e;
      push = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.w = sb.st_addr[31:2]; e.d = sb.st_data; e.be = sb.st_be; e.pc = sb.st_pc;
      q.push_back(e);
    end
  endfunction

  function automatic bit model_hit(logic [31:0] a);
    foreach (q[i]) if (q[i].w == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clk_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb.st_valid = 1'b0; sb.st_addr = '0; sb.st_data = '0; sb.st_be = '0; sb.st_pc = '0;
    sb.ld_valid = 1'b0; sb.ld_addr = '0; sb.dm_ready = 1'b0;
  endtask

  task automatic drive_store(logic [31:0] a, logic [31:0] d, logic [3:0] be, logic [31:0] pc);
    sb.st_valid = 1'b1; sb.st_addr = a; sb.st_data = d; sb.st_be = be; sb.st_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    sb.ld_valid = 1'b1;
    #12;
    checks++;
    if ({sb.st_ready, sb.empty, sb.dm_we, sb.ld_conflict} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 1100", {sb.st_ready, sb.empty, sb.dm_we, sb.ld_conflict});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    q.delete();
    sb.ld_valid = 1'b0;
    #1;
    checks++;
    if ({sb.st_ready, sb.empty, sb.dm_we} !== 3'b110) begin
      failures++;
      $display("FAIL post_reset_flags: got %b expected 110", {sb.st_ready, sb.empty, sb.dm_we});
    end
  endtask

  task automatic test_single();
    idle_inputs();
    sb.dm_ready = 1'b1;
    drive_store(32'h10, 32'h12345678, 4'b1111, 32'h3000);
    clk_edge();
    sb.st_valid = 1'b0;
    #1;
    checks++;
    if ({sb.dm_we, sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc} !== {1'b1, 32'h10, 32'h12345678, 4'hF, 32'h3000}) begin
      failures++;
      $display("FAIL single_present: got we=%b a=%h d=%h be=%b pc=%h expected 1 10 12345678 1111 3000",
               sb.dm_we, sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc);
    end
    clk_edge();
    checks++;
    if ({sb.empty, sb.dm_we} !== 2'b10) begin
      failures++;
      $display("FAIL single_drained: got empty,we=%b expected 10", {sb.empty, sb.dm_we});
    end
  endtask

  task automatic test_fill_drain();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      drive_store(32'(4*k), $urandom, 4'b1111, 32'(32'h100 + k));
      clk_edge();
    end
    drive_store(32'h20, 32'hDEADBEEF, 4'b1111, 32'h200);
    #1;
    checks++;
    if (sb.st_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: got %b expected 0", sb.st_ready);
    end
    clk_edge();
    sb.st_valid = 1'b0;
    sb.dm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({sb.dm_we, sb.dm_addr, sb.dm_pc} !== {1'b1, 32'(4*k), 32'(32'h100 + k)}) begin
        failures++;
        $display("FAIL drain_order[%0d]: got we=%b a=%h pc=%h expected 1 %h %h",
                 k, sb.dm_we, sb.dm_addr, sb.dm_pc, 32'(4*k), 32'(32'h100 + k));
      end
      clk_edge();
      if (k == 0) begin
        checks++;
        if (sb.st_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop: got %b expected 1", sb.st_ready);
        end
      end
    end
    checks++;
    if (sb.empty !== 1'b1) begin
      failures++;
      $display("FAIL fifth_dropped: got empty=%b expected 1", sb.empty);
    end
  endtask

  task automatic test_coalesce();
    idle_inputs();
    drive_store(32'h21, 32'h0000AA00, 4'b0010, 32'h400);
    clk_edge();
    drive_store(32'h23, 32'hBB000000, 4'b1000, 32'h404);
    clk_edge();
    sb.st_valid = 1'b0;
    #1;
    checks++;
    if ({sb.dm_we, sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc} !== {1'b1, 32'h20, 32'hBB00AA00, 4'b1010, 32'h404}) begin
      failures++;
      $display("FAIL coalesce_head: got we=%b a=%h d=%h be=%b pc=%h expected 1 20 bb00aa00 1010 404",
               sb.dm_we, sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc);
    end
    sb.dm_ready = 1'b1;
    clk_edge();
    checks++;
    if (sb.empty !== 1'b1) begin
      failures++;
      $display("FAIL coalesce_single_entry: got empty=%b expected 1", sb.empty);
    end
  endtask

  task automatic test_ld_conflict();
    idle_inputs();
    drive_store(32'h40, 32'h11223344, 4'b1111, 32'h500);
    clk_edge();
    sb.st_valid = 1'b0;
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h42;
    #1;
    checks++;
    if (sb.ld_conflict !== 1'b1) begin
      failures++;
      $display("FAIL ld_hit: got %b expected 1", sb.ld_conflict);
    end
    sb.ld_addr = 32'h44;
    #1;
    checks++;
    if (sb.ld_conflict !== 1'b0) begin
      failures++;
      $display("FAIL ld_miss: got %b expected 0", sb.ld_conflict);
    end
    sb.ld_addr  = 32'h42;
    sb.dm_ready = 1'b1;
    clk_edge();
    checks++;
    if (sb.ld_conflict !== 1'b0) begin
      failures++;
      $display("FAIL ld_after_pop: got %b expected 0", sb.ld_conflict);
    end
  endtask

  task automatic test_pop_same_word();
    idle_inputs();
    drive_store(32'h8, 32'hA5A5A5A5, 4'b1111, 32'h600);
    clk_edge();
    sb.dm_ready = 1'b1;
    drive_store(32'h8, 32'h000000CC, 4'b0001, 32'h604);
    #1;
    checks++;
    if ({sb.dm_wd, sb.dm_be, sb.dm_pc} !== {32'hA5A5A5A5, 4'b1111, 32'h600}) begin
      failures++;
      $display("FAIL pop_unmodified: got d=%h be=%b pc=%h expected a5a5a5a5 1111 600", sb.dm_wd, sb.dm_be, sb.dm_pc);
    end
    clk_edge();
    sb.st_valid = 1'b0;
    sb.dm_ready = 1'b0;
    #1;
    checks++;
    if ({sb.dm_we, sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc} !== {1'b1, 32'h8, 32'h000000CC, 4'b0001, 32'h604}) begin
      failures++;
      $display("FAIL pop_realloc: got we=%b a=%h d=%h be=%b pc=%h expected 1 8 000000cc 0001 604",
               sb.dm_we, sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc);
    end
    sb.dm_ready = 1'b1;
    clk_edge();
    checks++;
    if (sb.empty !== 1'b1) begin
      failures++;
      $display("FAIL pop_realloc_count: got empty=%b expected 1", sb.empty);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      drive_store(32'(32'h80 + 8*k), $urandom, 4'b1111, 32'(32'h700 + k));
      clk_edge();
    end
    sb.st_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({sb.st_ready, sb.empty, sb.dm_we} !== 3'b110) begin
      failures++;
      $display("FAIL async_reset: got ready,empty,we=%b expected 110", {sb.st_ready, sb.empty, sb.dm_we});
    end
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    sb.dm_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sb.dm_we !== 1'b0) begin
        failures++;
        $display("FAIL stale_entry[%0d]: got dm_we=%b expected 0", k, sb.dm_we);
      end
      clk_edge();
    end
  endtask

  task automatic test_random();
    logic [3:0] legal [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000};
    bit         exp_we;
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      sb.st_valid = ($urandom_range(0, 3) != 0);
      sb.st_addr  = {26'h0, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      sb.st_data  = $urandom;
      sb.st_be    = legal[$urandom_range(0, 7)];
      sb.st_pc    = 32'(32'h8000 + 4*n);
      sb.ld_valid = $urandom_range(0, 1) == 1;
      sb.ld_addr  = {26'h0, 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      sb.dm_ready = ($urandom_range(0, 2) == 0);
      #1;
      exp_we = (q.size() != 0);
      checks++;
      if ({sb.st_ready, sb.empty, sb.dm_we, sb.ld_conflict} !==
          {q.size() < DEPTH, !exp_we, exp_we, sb.ld_valid && model_hit(sb.ld_addr)}) begin
        failures++;
        $display("FAIL rand_flags[%0d]: got %b expected %b", n,
                 {sb.st_ready, sb.empty, sb.dm_we, sb.ld_conflict},
                 {q.size() < DEPTH, !exp_we, exp_we, sb.ld_valid && model_hit(sb.ld_addr)});
      end
      if (exp_we) begin
        checks++;
        if ({sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc} !== {q[0].w, 2'b00, q[0].d, q[0].be, q[0].pc}) begin
          failures++;
          $display("FAIL rand_head[%0d]: got a=%h d=%h be=%b pc=%h expected %h %h %b %h", n,
                   sb.dm_addr, sb.dm_wd, sb.dm_be, sb.dm_pc, {q[0].w, 2'b00}, q[0].d, q[0].be, q[0].pc);
        end
      end
      clk_edge();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_coalesce();
    test_ld_conflict();
    test_pop_same_word();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
